// File: rtl/mem_dma.sv
// mem_dma: word-copy DMA engine, MMIO-configured, driving
// the native memory bus as a master (one read + one write beat per word).
module mem_dma #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LEN_WIDTH      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done_pulse
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t               state_q, state_d;
    logic                 valid_q, valid_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          buf_q, buf_d;
    logic [31:0]          src_q, src_d;
    logic [31:0]          dst_q, dst_d;
    logic [29:0]          src_r_q, src_r_d;
    logic [29:0]          dst_r_q, dst_r_d;
    logic [LEN_WIDTH-1:0] len_r_q, len_r_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] idx_q, idx_d, idx_inc;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 pulse_q, pulse_d;
    logic                 busy_q, busy_d;
    logic                 abort_q, abort_d;
    logic                 reg_wr, ctrl_wr, start, abort, abort_any;
    logic                 fin, fail;

    assign reg_wr    = cs & we;
    assign ctrl_wr   = reg_wr && (address == 8'h08);
    assign start     = ctrl_wr & write_data[0];
    assign abort     = ctrl_wr & write_data[1];
    assign abort_any = abort_q | abort;
    assign idx_inc   = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        src_d   = src_q;
        dst_d   = dst_q;
        src_r_d = src_r_q;
        dst_r_d = dst_r_q;
        len_r_d = len_r_q;
        len_d   = len_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        done_d  = done_q;
        err_d   = err_q;
        pulse_d = 1'b0;
        abort_d = abort_q;
        fin     = 1'b0;
        fail    = 1'b0;

        if (reg_wr && !busy_q) begin
            case (address)
                8'h10:   src_r_d = write_data[31:2];
                8'h11:   dst_r_d = write_data[31:2];
                8'h12:   len_r_d = write_data[LEN_WIDTH-1:0];
                default: ;
            endcase
        end
        if (reg_wr && address == 8'h09) begin
            if (write_data[1]) done_d = 1'b0;
            if (write_data[2]) err_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start && len_r_q == '0) begin
                    done_d  = 1'b1;
                    pulse_d = 1'b1;
                end else if (start) begin
                    src_d   = {src_r_q, 2'b00};
                    dst_d   = {dst_r_q, 2'b00};
                    len_d   = len_r_q;
                    idx_d   = '0;
                    tcnt_d  = '0;
                    abort_d = 1'b0;
                    addr_d  = {src_r_q, 2'b00};
                    valid_d = 1'b1;
                    state_d = RD;
                end
            end
            RD, WR: begin
                if (start && !abort) err_d = 1'b1;
                if (abort) abort_d = 1'b1;
                if (valid_q && mem_ready) begin
                    valid_d = 1'b0;
                    if (state_q == RD) begin
                        buf_d   = mem_rdata;
                        state_d = WR;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = RD;
                        if (idx_inc == len_q) fin = 1'b1;
                    end
                    if (abort_any) begin
                        fin  = 1'b1;
                        fail = 1'b1;
                    end
                end else if (valid_q) begin
                    if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        fin  = 1'b1;
                        fail = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end else if (abort_any) begin
                    // Between beats nothing is in flight, so stop here.
                    fin  = 1'b1;
                    fail = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    tcnt_d  = '0;
                    addr_d  = (state_q == RD ? src_q : dst_q)
                            + 32'({idx_q, 2'b00});
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            pulse_d = 1'b1;
            abort_d = 1'b0;
            if (fail) err_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            buf_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            src_r_q <= '0;
            dst_r_q <= '0;
            len_r_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            tcnt_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            src_r_q <= src_r_d;
            dst_r_q <= dst_r_d;
            len_r_q <= len_r_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        read_data = '0;
        case (address)
            8'h00:   read_data = 32'h646d_6120;
            8'h02:   read_data = 32'h0000_0001;
            8'h09:   read_data = {29'd0, err_q, done_q, busy_q};
            8'h10:   read_data = {src_r_q, 2'b00};
            8'h11:   read_data = {dst_r_q, 2'b00};
            8'h12:   read_data = 32'(len_r_q);
            default: read_data = '0;
        endcase
    end

    assign ready      = cs;
    assign mem_valid  = valid_q;
    assign mem_addr   = addr_q;
    assign mem_wstrb  = (state_q == WR) ? 4'hF : 4'h0;
    assign mem_wdata  = buf_q;
    assign busy       = busy_q;
    assign done_pulse = pulse_q;

endmodule
